seq_bin_to_bcd: RTL and testbench
=================================

// Module: seq_bin_to_bcd
// PURPOSE
//  Iterative (shift-add-3 / double-dabble) binary-to-BCD converter for the product display path.
//  Sits after the sign/abs stage: consumes the 16-bit magnitude and feeds five registered digits to the digit selector.
//  Its start/done handshake lets the display path update only when a new product is loaded.
// PARAMETERS
//  WIDTH   16  binary input width; also the number of SHIFT cycles
//  DIGITS  5   BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1
// PORTS
//  clk    in   1        system clock (slow display-domain clock); all logic on rising edge
//  R      in   1        reset, synchronous, active-high
//  start  in   1        request conversion of bin; sampled only in IDLE
//  bin    in   WIDTH    unsigned magnitude to convert
//  busy   out  1        high from the cycle after start acceptance through the DONE cycle
//  done   out  1        one-cycle pulse; d0..d4 are valid from this cycle on
//  d0     out  5        units digit, {1'b0,BCD}
//  d1..d4 out  5 each   tens..ten-thousands digits, same format
// BEHAVIOUR
//  Reset: on clk edge with R=1, FSM->IDLE, busy=0, done=0, d0..d4=5'd0, scratch cleared. Reset takes priority over start.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: on start=1, latch bin into shift reg, clear 4*DIGITS-bit BCD scratch, cnt=WIDTH, go SHIFT.
//   SHIFT: per cycle, for each BCD nibble >=5 add 3, then shift {bcd,sh} left 1. cnt-- ; after the WIDTH-th shift go DONE.
//   DONE: copy scratch nibbles to d0..d4 (bit4=0), done=1 for exactly this cycle, go IDLE.
//  Latency: start sampled at edge 0 -> done=1 after edge WIDTH+1 (17 for defaults).
//   Outputs hold last result until next DONE; they never show partial values.
//  start while busy (SHIFT or DONE) ignored; no queueing; bin changes after acceptance ignored.
//  Back-to-back: start held high re-triggers in the IDLE cycle after DONE (period WIDTH+2).
//  Reset mid-conversion: aborts immediately, outputs return to 0, no done pulse.
//  Arithmetic: add-3 per nibble is 4-bit, no carry out; max input 65535 -> 6,5,5,3,5; no overflow path.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   In DONE, every digit above the most significant nonzero digit is set to 5'h1F (blank code for the display driver).
//   d0 is never blanked (bin=0 shows "0").
//  Not defined: all digits output as {1'b0,BCD}, leading zeros shown; 5'h1F never produced.
// TESTING
//  Reset: R=1 for 2 cycles -> busy=0, done=0, d0..d4=0.
//  bin=0, start pulse -> done at cycle 17; all digits 0; with _EN: d4..d1=1F, d0=0.
//  bin=65535 -> d4=6, d3=5, d2=5, d1=3, d0=5, done exactly 1 cycle, busy high for cycles 1..17.
//  bin=1234 -> d3=1, d2=2, d1=3, d0=4, d4=0 (with _EN: d4=1F).
//  start re-pulsed at cycle 5 with bin=9999 during a 1234 conversion -> ignored; result stays 1234.
//  R=1 at cycle 8 mid-conversion -> next cycle busy=0, digits 0, no done.
//  New start with bin=42 -> prior 1234 digits held until its DONE.

Source files
------------

// File: rtl/seq_bin_to_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_bin_to_bcd_if
//  Brief    : start/done handshake, binary operand and BCD digit bundle for
//             the iterative binary-to-BCD converter.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_bin_to_bcd_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [4:0]       d0;
    logic [4:0]       d1;
    logic [4:0]       d2;
    logic [4:0]       d3;
    logic [4:0]       d4;

    modport master (
        output start, bin,
        input  busy, done, d0, d1, d2, d3, d4
    );

    modport slave (
        input  start, bin,
        output busy, done, d0, d1, d2, d3, d4
    );
endinterface
`default_nettype wire

// File: rtl/seq_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : seq_bin_to_bcd
//  Brief    : Iterative shift-add-3 (double-dabble) binary-to-BCD converter,
//             one bit per clock, five registered digits with a done pulse.
//             Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros (5'h1F).
//  Revision : 1.0  initial release
// ============================================================================
module seq_bin_to_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  wire logic          clk,
    input  wire logic          R,
    seq_bin_to_bcd_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_accept;
    logic [WIDTH-1:0]          r_sh;
    logic [BCD_W-1:0]          r_bcd;
    logic [BCD_W-1:0]          w_bcd_adj;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_busy;
    logic                      r_done;
    logic [DIGITS-1:0][4:0]    r_dig;
    logic [DIGITS-1:0][4:0]    w_dig_out;

    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Correct every nibble that would exceed 9 after the coming doubling.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                        ? (r_bcd[4*gi +: 4] + 4'd3)
                                        : r_bcd[4*gi +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin : p_blank
        logic w_lead;
        w_lead    = 1'b1;
        w_dig_out = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (r_bcd[4*i +: 4] == 4'd0)) begin
                w_dig_out[i] = 5'h1F;
            end else begin
                w_lead       = 1'b0;
                w_dig_out[i] = {1'b0, r_bcd[4*i +: 4]};
            end
        end
        w_dig_out[0] = {1'b0, r_bcd[3:0]};
    end
`else
    generate
        for (genvar gd = 0; gd < DIGITS; gd++) begin : g_dig
            assign w_dig_out[gd] = {1'b0, r_bcd[4*gd +: 4]};
        end
    endgenerate
`endif

    // busy covers SHIFT, DONE and the done-pulse cycle; in IDLE it follows acceptance.
    always_ff @(posedge clk) begin
        if (R) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dig  <= '0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (r_state == S_IDLE) ? w_accept : 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sh  <= bus.bin;
                        r_bcd <= '0;
                        r_cnt <= CNT_W'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_sh} <= {w_bcd_adj[BCD_W-2:0], r_sh, 1'b0};
                    r_cnt         <= r_cnt - CNT_W'(1);
                end
                S_DONE: begin
                    r_dig  <= w_dig_out;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.d0   = r_dig[0];
    assign bus.d1   = r_dig[1];
    assign bus.d2   = r_dig[2];
    assign bus.d3   = r_dig[3];
    assign bus.d4   = r_dig[4];

endmodule
`default_nettype wire

// File: tb/tb_seq_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_bin_to_bcd
//  Brief    : Self-checking bench for seq_bin_to_bcd: vector table, random
//             values against a divide/modulo model, and handshake corner cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_bin_to_bcd;

    logic clk;
    logic R;
    int   checks;
    int   failures;
    logic [24:0] prev_exp;

    seq_bin_to_bcd_if #(.WIDTH(16)) bus ();

    seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [24:0] exp;   // {d4,d3,d2,d1,d0}, leading zeros shown
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [24:0] blank(input logic [24:0] p);
        logic [24:0] r;
        r = p;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 4; i >= 1; i--) begin
            if (r[5*i +: 5] != 5'd0) break;
            r[5*i +: 5] = 5'h1F;
        end
`endif
        return r;
    endfunction

    function automatic logic [24:0] model(input int unsigned v);
        logic [24:0] m;
        int unsigned x;
        x = v;
        m = '0;
        for (int i = 0; i < 5; i++) begin
            m[5*i +: 5] = 5'(x % 10);
            x = x / 10;
        end
        return blank(m);
    endfunction

    function automatic logic [24:0] digits();
        return {bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
    endfunction

    function automatic logic [24:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {5'(a), 5'(b), 5'(c), 5'(d), 5'(e)};
    endfunction

    // One conversion; optionally re-pulses start (bin=9999) at edge rs_cycle.
    task automatic run_conv(input logic [15:0] v, input logic [24:0] exp,
                            input int rs_cycle, input string nm);
        int done_cnt;
        int done_at;
        bit busy_ok;
        bit hold_ok;
        done_cnt = 0;
        done_at  = -1;
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 16'($urandom);
        if (!bus.busy) busy_ok = 1'b0;
        if (bus.done) done_cnt++;
        for (int k = 1; k <= 17; k++) begin
            if (k == rs_cycle) begin
                bus.start = 1'b1;
                bus.bin   = 16'd9999;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                done_cnt++;
                done_at = k;
            end
            if (k < 17 && digits() !== prev_exp) hold_ok = 1'b0;
        end
        bus.start = 1'b0;
        chk({nm, " digits"}, 32'(digits()), 32'(exp));
        chk({nm, " done_at"}, 32'(done_at), 32'd17);
        chk({nm, " done_cnt"}, 32'(done_cnt), 32'd1);
        chk({nm, " busy_hi"}, 32'(busy_ok), 32'd1);
        chk({nm, " hold"}, 32'(hold_ok), 32'd1);
        @(negedge clk);
        chk({nm, " busy_end"}, 32'(bus.busy), 32'd0);
        chk({nm, " done_end"}, 32'(bus.done), 32'd0);
        prev_exp = exp;
    endtask

    initial begin
        int dn;
        bit busy_ok;
        logic [15:0] rv;
        checks    = 0;
        failures  = 0;
        prev_exp  = '0;
        R         = 1'b1;
        bus.start = 1'b1;
        bus.bin   = 16'd777;

        vecs[0]  = '{16'd0,     pk(0,0,0,0,0)};
        vecs[1]  = '{16'd65535, pk(6,5,5,3,5)};
        vecs[2]  = '{16'd1234,  pk(0,1,2,3,4)};
        vecs[3]  = '{16'd9,     pk(0,0,0,0,9)};
        vecs[4]  = '{16'd10,    pk(0,0,0,1,0)};
        vecs[5]  = '{16'd99,    pk(0,0,0,9,9)};
        vecs[6]  = '{16'd1000,  pk(0,1,0,0,0)};
        vecs[7]  = '{16'd10000, pk(1,0,0,0,0)};
        vecs[8]  = '{16'd9999,  pk(0,9,9,9,9)};
        vecs[9]  = '{16'd50005, pk(5,0,0,0,5)};
        vecs[10] = '{16'd40960, pk(4,0,9,6,0)};
        vecs[11] = '{16'd32768, pk(3,2,7,6,8)};

        // Reset held two cycles with start asserted: reset wins.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst digits", 32'(digits()), 32'd0);
        bus.start = 1'b0;
        R = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].bin, blank(vecs[i].exp), -1, $sformatf("vec%0d", i));
        end

        run_conv(16'd1234, blank(pk(0,1,2,3,4)), 5, "restart_ignored");
        run_conv(16'd42, blank(pk(0,0,0,4,2)), -1, "hold_then_42");

        // Reset during conversion: abort, clear digits, no done afterwards.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        R = 1'b0;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst digits", 32'(digits()), 32'd0);
        dn = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        chk("midrst quiet", 32'(dn), 32'd0);
        prev_exp = '0;

        for (int i = 0; i < 20; i++) begin
            rv = 16'($urandom);
            run_conv(rv, model(32'(rv)), (i % 4 == 0) ? 9 : -1, $sformatf("rnd%0d_%0d", i, rv));
        end

        // Start held high: back-to-back conversions with period 18.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd1234;
        dn      = 0;
        busy_ok = 1'b1;
        for (int k = 0; k <= 35; k++) begin
            @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                dn++;
                if (k != 17 && k != 35) chk("b2b done_pos", 32'(k), 32'd17);
            end
            if (k == 17) begin
                chk("b2b done17", 32'(bus.done), 32'd1);
                chk("b2b first", 32'(digits()), 32'(model(1234)));
                bus.bin = 16'd42;
            end
            if (k == 18) bus.start = 1'b0;
        end
        chk("b2b done35", 32'(bus.done), 32'd1);
        chk("b2b second", 32'(digits()), 32'(model(42)));
        chk("b2b done_cnt", 32'(dn), 32'd2);
        chk("b2b busy", 32'(busy_ok), 32'd1);
        @(negedge clk);
        chk("b2b busy_end", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
